// File: rtl/btn_cond.sv
// btn_cond: three-key push-button conditioner.
//   Each raw active-low key is double-flop synchronized, then debounced by an
//   independent IDLE/PRESS_CHK/HELD/REL_CHK state machine. A debounced press
//   produces a one-cycle pulse on the key's output; held[] reports the
//   debounced pressed level.
//
//   Optional feature macro: BTN_REPEAT_EN
//     When defined, a key that stays in HELD re-pulses REPEAT_DELAY cycles
//     after entering HELD and every REPEAT_PERIOD cycles thereafter.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 2)
//   REPEAT_DELAY     cycles in HELD before the first auto-repeat pulse
//   REPEAT_PERIOD    cycles between subsequent auto-repeat pulses
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high
//   key_n    in   [2:0] raw buttons, active-low (0 start, 1 pfinish, 2 stop)
//   start    out  press pulse for key_n[0]
//   pfinish  out  press pulse for key_n[1]
//   stop     out  press pulse for key_n[2]
//   held     out  [2:0] debounced pressed level, 1 = pressed
module btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_n,
  output logic       start,
  output logic       pfinish,
  output logic       stop,
  output logic [2:0] held
);

  localparam int unsigned MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned CNT_MAX = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DB_CNT = CW'(DEBOUNCE_CYCLES);
`ifdef BTN_REPEAT_EN
  localparam logic [CW-1:0] RD_CNT = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RP_CNT = CW'(REPEAT_PERIOD);
`endif

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_REL_CHK   = 2'd3;

  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [1:0]    state_q [3];
  logic [1:0]    state_d [3];
  logic [CW-1:0] cnt_q   [3];
  logic [CW-1:0] cnt_d   [3];
  logic [CW-1:0] cnt_inc;
  logic [2:0]    pulse_q, pulse_d;
  logic [2:0]    held_q, held_d;
`ifdef BTN_REPEAT_EN
  // 0: waiting for the initial repeat delay, 1: in the periodic phase
  logic [2:0]    rep_q, rep_d;
`endif

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    pulse_d = '0;
    held_d  = '0;
    cnt_inc = '0;
`ifdef BTN_REPEAT_EN
    rep_d   = rep_q;
`endif
    for (int unsigned i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      // saturating increment
      cnt_inc    = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CW'(1);
      case (state_q[i])
        ST_IDLE: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_PRESS_CHK;
            cnt_d[i]   = CW'(1);
          end
        end
        ST_PRESS_CHK: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_inc >= DB_CNT) begin
            state_d[i] = ST_HELD;
            cnt_d[i]   = '0;
            pulse_d[i] = 1'b1;
`ifdef BTN_REPEAT_EN
            rep_d[i]   = 1'b0;
`endif
          end else begin
            cnt_d[i]   = cnt_inc;
          end
        end
        ST_HELD: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_REL_CHK;
            cnt_d[i]   = CW'(1);
          end
`ifdef BTN_REPEAT_EN
          else if (cnt_inc >= (rep_q[i] ? RP_CNT : RD_CNT)) begin
            cnt_d[i]   = '0;
            pulse_d[i] = 1'b1;
            rep_d[i]   = 1'b1;
          end else begin
            cnt_d[i]   = cnt_inc;
          end
`endif
        end
        ST_REL_CHK: begin
          if (!sync2_q[i]) begin
            // glitch on release: back to HELD with repeat timing restarted
            state_d[i] = ST_HELD;
            cnt_d[i]   = '0;
`ifdef BTN_REPEAT_EN
            rep_d[i]   = 1'b0;
`endif
          end else if (cnt_inc >= DB_CNT) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_inc;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      held_d[i] = (state_d[i] == ST_HELD) || (state_d[i] == ST_REL_CHK);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      pulse_q <= '0;
      held_q  <= '0;
`ifdef BTN_REPEAT_EN
      rep_q   <= '0;
`endif
      for (int unsigned i = 0; i < 3; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
`ifdef BTN_REPEAT_EN
      rep_q   <= rep_d;
`endif
      for (int unsigned i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign start   = pulse_q[0];
  assign pfinish = pulse_q[1];
  assign stop    = pulse_q[2];
  assign held    = held_q;

endmodule

// File: tb/tb_btn_cond.sv
// Testbench for btn_cond with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. A reference model predicts held[] every cycle and every
// pulse vector; a monitor pops and compares those predictions.
module tb_btn_cond;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk;
  logic       reset;
  logic [2:0] key_n;
  logic       start, pfinish, stop;
  logic [2:0] held;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  v;
  } ev_t;

  ev_t        pq[$];
  logic [2:0] hq[$];

  btn_cond #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .key_n  (key_n),
    .start  (start),
    .pfinish(pfinish),
    .stop   (stop),
    .held   (held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a debounced level flips once the synchronized sample has
  // disagreed with it for DB consecutive cycles; any agreeing sample resets the
  // disagreement run. Repeat timing counts cycles of agreement while pressed.
  logic [2:0] m_s1 = '1, m_s2 = '1;
  bit         m_lvl [3];
  int         m_run [3];
  int         m_age [3];

  always @(posedge clk) begin
    logic [2:0] s, p, lv;
    ev_t        e;
    cyc = cyc + 1;
    p = '0;
    if (reset) begin
      m_s1 = '1;
      m_s2 = '1;
      for (int k = 0; k < 3; k++) begin
        m_lvl[k] = 0; m_run[k] = 0; m_age[k] = 0;
      end
    end else begin
      s = m_s2;
      for (int k = 0; k < 3; k++) begin
        bit pressed_now;
        pressed_now = !s[k];
        if (!m_lvl[k]) begin
          if (pressed_now) begin
            m_run[k]++;
            if (m_run[k] == DB) begin
              m_lvl[k] = 1; m_run[k] = 0; m_age[k] = 0; p[k] = 1'b1;
            end
          end else m_run[k] = 0;
        end else begin
          if (!pressed_now) begin
            m_run[k]++;
            if (m_run[k] == DB) begin
              m_lvl[k] = 0; m_run[k] = 0;
            end
          end else if (m_run[k] > 0) begin
            m_run[k] = 0; m_age[k] = 0;
          end else begin
            m_age[k]++;
`ifdef BTN_REPEAT_EN
            if (m_age[k] == RD || (m_age[k] > RD && (m_age[k] - RD) % RP == 0))
              p[k] = 1'b1;
`endif
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = key_n;
    end
    for (int k = 0; k < 3; k++) lv[k] = m_lvl[k];
    hq.push_back(lv);
    if (p != 3'b000) begin
      e.cyc = cyc;
      e.v   = p;
      pq.push_back(e);
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [2:0] exp_h, exp_p, got_p;
    ev_t        e;
    if (cyc > 0) begin
      total++;
      if (hq.size() == 0) begin
        bad++;
        $display("FAIL held_queue_empty cyc=%0d", cyc);
      end else begin
        exp_h = hq.pop_front();
        if (held !== exp_h) begin
          bad++;
          $display("FAIL held cyc=%0d got=%b want=%b", cyc, held, exp_h);
        end
      end
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
        e = pq.pop_front();
        total++; bad++;
        $display("FAIL pulse_missed cyc=%0d got=none want=%b", e.cyc, e.v);
      end
      exp_p = '0;
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        e = pq.pop_front();
        exp_p = e.v;
      end
      got_p = {stop, pfinish, start};
      if (got_p !== 3'b000 || exp_p != 3'b000) begin
        total++;
        if (got_p !== exp_p) begin
          bad++;
          $display("FAIL pulses cyc=%0d got=%b want=%b", cyc, got_p, exp_p);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Count cycles with key k's pulse high over n cycles; 'at' is the 1-based
  // cycle of the first pulse, 0 if none.
  task automatic wait_pulse(input int k, input int n, output int cnt, output int at);
    logic [2:0] v;
    cnt = 0;
    at  = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      v = {stop, pfinish, start};
      if (v[k] === 1'b1) begin
        cnt++;
        if (at == 0) at = i;
      end
    end
  endtask

  task automatic idle(input int n);
    key_n = '1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c, a, c2, a2, rel_at;
    logic [2:0] v6;
    reset = 1'b1;
    key_n = '1;
    repeat (3) @(negedge clk);
    check("reset_held", int'(held), 0);
    check("reset_pulses", int'({stop, pfinish, start}), 0);
    reset = 1'b0;
    idle(5);

    // Clean press on start
    key_n[0] = 1'b0;
    wait_pulse(0, 12, c, a);
    check("clean_count", c, 1);
    check("clean_latency", a, 6);
    idle(20);

    // Bounce on pfinish
    key_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    key_n[1] = 1'b1;
    @(negedge clk);
    key_n[1] = 1'b0;
    wait_pulse(1, 12, c, a);
    check("bounce_count", c, 1);
    check("bounce_latency", a, 6);
    idle(20);

    // Release glitch on stop, then clean release
    key_n[2] = 1'b0;
    wait_pulse(2, 10, c, a);
    check("glitch_first_pulse", c, 1);
    key_n[2] = 1'b1;
    repeat (2) @(negedge clk);
    key_n[2] = 1'b0;
    wait_pulse(2, 15, c, a);
    check("glitch_no_repulse", c, 0);
    check("glitch_held", int'(held[2]), 1);
    key_n[2] = 1'b1;
    rel_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rel_at == 0 && held[2] === 1'b0) rel_at = i;
    end
    check("release_latency", rel_at, 6);
    idle(10);

    // Simultaneous press
    key_n = 3'b000;
    v6 = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 6) v6 = {stop, pfinish, start};
    end
    check("simultaneous", int'(v6), 7);
    idle(20);

    // Reset mid-press
    key_n[2] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_pulse(2, 3, c, a);
    check("reset_abort", c, 0);
    reset = 1'b0;
    wait_pulse(2, 10, c, a);
    check("post_reset_count", c, 1);
    check("post_reset_latency", a, 6);
    idle(20);

    // Long hold (auto-repeat when enabled)
    key_n[0] = 1'b0;
    wait_pulse(0, 50, c, a);
    key_n[0] = 1'b1;
    wait_pulse(0, 15, c2, a2);
    check("hold_first_latency", a, 6);
`ifdef BTN_REPEAT_EN
    check("hold_pulse_count", c + c2, 5);
`else
    check("hold_pulse_count", c + c2, 1);
`endif
    idle(20);

    // Randomized segments with varying toggle rates and occasional resets
    for (int seg = 0; seg < 6; seg++) begin
      for (int n = 0; n < 500; n++) begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range((seg % 3 == 0) ? 3 : (seg % 3 == 1) ? 11 : 39, 0) == 0)
            key_n[k] = ~key_n[k];
        end
        reset = ($urandom_range(299, 0) == 0);
      end
    end
    reset = 1'b0;
    idle(40);

    check("pulse_queue_drained", pq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/btn_cond.md
BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable clk cycles needed to accept a level change (10 ms at 50 MHz; minimum 2).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, held cycles before the first auto-repeat pulse (used only with BTN_REPEAT_EN).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10000000, cycles between subsequent auto-repeat pulses (used only with BTN_REPEAT_EN).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port key_n  input  3  raw asynchronous push-buttons, active-low; bit0 = start, bit1 = pfinish, bit2 = stop.
REQ-007 SHALL have port start  output  1  one-cycle press pulse for key_n[0].
REQ-008 SHALL have port pfinish  output  1  one-cycle press pulse for key_n[1].
REQ-009 SHALL have port stop  output  1  one-cycle press pulse for key_n[2].
REQ-010 SHALL have port held  output  3  debounced pressed level per key, 1 = pressed.

Function
REQ-011 SHALL pass each key_n bit through a 2-flop synchronizer before any other logic; the synchronized level s is active-low.
REQ-012 SHALL run one independent FSM per key with states IDLE, PRESS_CHK, HELD and REL_CHK, each with its own counter of width clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).
REQ-013 In IDLE, s = 0 SHALL move the FSM to PRESS_CHK with counter = 1.
REQ-014 In PRESS_CHK, s = 0 SHALL increment the counter; when the counter reaches DEBOUNCE_CYCLES the FSM SHALL enter HELD and assert that key's press pulse for exactly one cycle.
REQ-015 In PRESS_CHK, s = 1 (bounce) SHALL return the FSM to IDLE with counter = 0 and no pulse.
REQ-016 In HELD, s = 1 SHALL move the FSM to REL_CHK with counter = 1; counting in REL_CHK mirrors PRESS_CHK, and DEBOUNCE_CYCLES high cycles SHALL return it to IDLE with no pulse.
REQ-017 In REL_CHK, s = 0 SHALL return the FSM to HELD without a new press pulse.
REQ-018 held[i] SHALL be 1 in states HELD and REL_CHK and 0 otherwise, registered.
REQ-019 Latency from the first raw low sample to the press pulse SHALL be exactly DEBOUNCE_CYCLES + 2 cycles for a clean edge.
REQ-020 Keys SHALL be fully independent; any combination of pulses may be asserted in the same cycle, with no priority.
REQ-021 Counters SHALL saturate and never wrap.
REQ-022 A pulse SHALL never last longer than one cycle, and no two pulses on the same output SHALL occur without the FSM leaving HELD, except auto-repeat (REQ-026).

Reset
REQ-023 While reset = 1, all outputs SHALL be 0, all FSMs IDLE, all counters 0, and the synchronizer flops 1 (released).
REQ-024 Reset asserted mid-press SHALL abort the press with no pulse; a key still held after reset deasserts SHALL produce its press pulse DEBOUNCE_CYCLES + 2 cycles after the first cycle with reset = 0.

Configuration
REQ-025 Without macro BTN_REPEAT_EN, HELD SHALL produce no further pulses, and REPEAT_DELAY and REPEAT_PERIOD SHALL be unused.
REQ-026 With BTN_REPEAT_EN defined, a key continuously in HELD SHALL re-pulse once REPEAT_DELAY cycles after entering HELD and then every REPEAT_PERIOD cycles; leaving HELD (including for REL_CHK) SHALL cancel repeat timing, and a return to HELD from REL_CHK SHALL restart REPEAT_DELAY.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-027 Clean press: key_n[0] goes 1->0 and holds -> start = 1 exactly 6 cycles later for 1 cycle and held[0] = 1 from the same cycle; no other output toggles.
REQ-028 Bounce: key_n[1] low 3 cycles, high 1, then low steady -> a single pfinish pulse 6 cycles after the final fall.
REQ-029 Release glitch: key_n[2] held, then high 2 cycles and low again -> held[2] stays 1 and no second stop pulse; a clean release drops held[2] 6 cycles after going high.
REQ-030 Simultaneous: all keys fall in the same cycle -> start, pfinish and stop all pulse in the same cycle, 6 cycles later.
REQ-031 Reset: reset asserted 2 cycles into a press -> no pulse; key still low, reset released -> pulse 6 cycles after reset deasserts.
REQ-032 BTN_REPEAT_EN: key_n[0] held 50 cycles -> start pulses at HELD entry, then +20, +28, +36, +44 cycles; without the macro, exactly one pulse.
